// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_pkg
// Purpose  : Shared encodings and lane helper for the data-memory LSU.
//            - access size codes (byte / half / word / reserved)
//            - FSM state encoding (IDLE, RMW_WR)
//            - lane_idx(): lowest byte lane (0 = bits 7:0) touched by an
//              access, given the byte offset, size and byte order
// Revision : 1.0 - initial release
// ============================================================================
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  // Halfwords only look at off[1], so an odd offset is silently rounded down;
  // this is what gives the forced-aligned behaviour when alignment checks
  // are disabled. Words always start at lane 0.
  function automatic logic [1:0] lane_idx(input logic [1:0] off,
                                          input logic [1:0] size,
                                          input logic       big_endian);
    logic [1:0] lane;
    lane = 2'd0;
    if (size == SZ_BYTE) begin
      lane = big_endian ? (2'd3 - off) : off;
    end else if (size == SZ_HALF) begin
      lane = big_endian ? (2'd2 - {off[1], 1'b0}) : {off[1], 1'b0};
    end
    return lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_mux
// Purpose  : Combinational byte-lane logic for the LSU.
//            - load path : extract byte/half at lane_i from word_i and
//                          sign- or zero-extend it; words pass through
//            - store path: merge wdata_i[7:0]/[15:0] into word_i at lane_i
// Ports    : word_i     memory word being read
//            size_i     access size code
//            lane_i     lowest byte lane of the access
//            unsigned_i 1 = zero-extend loads
//            wdata_i    right-justified store data
//            load_o     extended load result
//            merge_o    word_i with the store data merged in
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_mux
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_shamt = {lane_i, 3'b000};

  always_comb begin
    w_shifted = word_i >> w_shamt;
    load_o    = word_i;
    w_mask    = 32'hFFFF_FFFF;
    w_ins     = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{~unsigned_i & w_shifted[7]}}, w_shifted[7:0]};
        w_mask = 32'h0000_00FF << w_shamt;
        w_ins  = {24'd0, wdata_i[7:0]} << w_shamt;
      end
      SZ_HALF: begin
        load_o = {{16{~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
        w_mask = 32'h0000_FFFF << w_shamt;
        w_ins  = {16'd0, wdata_i[15:0]} << w_shamt;
      end
      default: begin
        load_o = word_i;
        w_mask = 32'hFFFF_FFFF;
        w_ins  = wdata_i;
      end
    endcase
    merge_o = (word_i & ~w_mask) | w_ins;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : M-stage load/store initiator for a word-addressed data memory
//            with async read and sync whole-word write. Adds sub-word loads
//            with extension, sub-word stores via a 2-cycle read-modify-write
//            (stalling the pipeline for one cycle), and misalign detection.
// Ports    : clk, reset          clock, sync active-high reset
//            req_*               M-stage request (valid/we/size/unsigned/
//                                addr/wdata)
//            rdata               combinational load result
//            stall               high on the first cycle of a sub-word store
//            misalign            current request is misaligned
//            mem_we/mem_a/mem_wd memory write port and word address
//            mem_rd              memory async read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int BIG_ENDIAN  = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic        w_mis_raw;
  logic        w_idle;
  logic        w_go;
  logic        w_we;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // With checking off, the reserved size degrades to a plain word access.
  assign w_size = (CHECK_ALIGN == 0 && req_size == SZ_RSVD) ? SZ_WORD : req_size;
  assign w_lane = lane_idx(req_addr[1:0], w_size, BIG_ENDIAN != 0);

  assign w_mis_raw = (req_size == SZ_RSVD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  // Requests are only looked at in IDLE; in RMW_WR the held store is ignored.
  assign w_idle   = (state_q == ST_IDLE) & ~reset;
  assign misalign = (CHECK_ALIGN != 0) & req_valid & w_mis_raw & w_idle;
  assign w_go     = req_valid & ~misalign & w_idle;

  lsu_lane_mux u_lane_mux (
    .word_i     (mem_rd),
    .size_i     (w_size),
    .lane_i     (w_lane),
    .unsigned_i (req_unsigned),
    .wdata_i    (req_wdata),
    .load_o     (w_load),
    .merge_o    (w_merge)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    w_we    = 1'b0;
    stall   = 1'b0;
    rdata   = 32'd0;
    mem_a   = {req_addr[31:2], 2'b00};
    mem_wd  = req_wdata;
    case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          if (!req_we) begin
            rdata = w_load;
          end else if (w_size == SZ_WORD) begin
            w_we = 1'b1;
          end else begin
            // Read half of the RMW: merge into the async read word and
            // park it for the write cycle.
            stall   = 1'b1;
            addr_d  = {req_addr[31:2], 2'b00};
            data_d  = w_merge;
            state_d = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        w_we    = 1'b1;
        mem_a   = addr_q;
        mem_wd  = data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    mem_we = w_we & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Self-checking bench for dmem_lsu. Two instances (little- and
//            big-endian) share the request inputs, each with its own memory
//            model; expected values come from a byte-oriented reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [31:0] rdata_le, a_le, wd_le, rd_le;
  logic [31:0] rdata_be, a_be, wd_be, rd_be;
  logic        stall_le, mis_le, we_le;
  logic        stall_be, mis_be, we_be;

  logic [31:0] mem_le [0:63];
  logic [31:0] mem_be [0:63];
  logic [31:0] ref_le [0:63];
  logic [31:0] ref_be [0:63];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.BIG_ENDIAN(0), .CHECK_ALIGN(1)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdata(rdata_le), .stall(stall_le),
    .misalign(mis_le), .mem_we(we_le), .mem_a(a_le), .mem_wd(wd_le),
    .mem_rd(rd_le));

  dmem_lsu #(.BIG_ENDIAN(1), .CHECK_ALIGN(1)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdata(rdata_be), .stall(stall_be),
    .misalign(mis_be), .mem_we(we_be), .mem_a(a_be), .mem_wd(wd_be),
    .mem_rd(rd_be));

  assign rd_le = mem_le[a_le[7:2]];
  assign rd_be = mem_be[a_be[7:2]];

  always @(posedge clk) begin
    if (we_le) mem_le[a_le[7:2]] <= wd_le;
    if (we_be) mem_be[a_be[7:2]] <= wd_be;
  end

  // ---------------- reference model (byte view of memory) ----------------
  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k, input bit be);
    int pos;
    pos = be ? 3 - k : k;
    return w[pos*8 +: 8];
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] w, input int k,
                                           input logic [7:0] b, input bit be);
    logic [31:0] r;
    int pos;
    r = w;
    pos = be ? 3 - k : k;
    r[pos*8 +: 8] = b;
    return r;
  endfunction

  function automatic bit ref_mis(input int a, input int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input int sz, input bit un, input bit be);
    int v;
    if (sz == 0) begin
      v = int'(get_byte(w, off, be));
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      if (be) v = int'(get_byte(w, off, be)) * 256 + int'(get_byte(w, off + 1, be));
      else    v = int'(get_byte(w, off + 1, be)) * 256 + int'(get_byte(w, off, be));
      if (!un && v >= 32768) v = v - 65536;
    end else begin
      return w;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int off,
                                            input int sz, input logic [31:0] d, input bit be);
    logic [31:0] r;
    r = w;
    if (sz == 0) begin
      r = set_byte(r, off, d[7:0], be);
    end else if (sz == 1) begin
      r = set_byte(r, off,     be ? d[15:8] : d[7:0],  be);
      r = set_byte(r, off + 1, be ? d[7:0]  : d[15:8], be);
    end else begin
      r = d;
    end
    return r;
  endfunction

  task automatic drive(input bit v, input bit we, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    drive(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", we_le); end
    n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", stall_le); end
    next_cycle;
    drive(1, 0, 2'd1, 0, 32'h41, 32'h0);
    @(negedge clk);
    n_cmp++; if (mis_le !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b exp 0", mis_le); end
    next_cycle;
    drive(1, 0, 2'd2, 0, 32'h40, 32'h0);
    @(negedge clk);
    n_cmp++; if (rdata_le !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0", rdata_le); end
    drive(1, 1, 2'd0, 0, 32'h41, 32'h77);
    @(negedge clk);
    n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL reset_sb_stall: got %b exp 0", stall_le); end
    next_cycle;
    reset = 1'b0;
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL reset_exit_we: got %b exp 0", we_le); end
    next_cycle;
    n_cmp++; if (mem_le[16] !== ref_le[16]) begin n_err++; $display("FAIL reset_mem: got %h exp %h", mem_le[16], ref_le[16]); end
  endtask

  task automatic test_loads;
    logic [31:0] exp;
    mem_le[4] = 32'h8899AABB; ref_le[4] = 32'h8899AABB;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 0, 2'd0, 0, 32'h11, 32'h0); exp = 32'hFFFFFFAA; end
        1: begin drive(1, 0, 2'd0, 1, 32'h11, 32'h0); exp = 32'h000000AA; end
        2: begin drive(1, 0, 2'd1, 0, 32'h12, 32'h0); exp = 32'hFFFF8899; end
        default: begin drive(1, 0, 2'd1, 1, 32'h12, 32'h0); exp = 32'h00008899; end
      endcase
      @(negedge clk);
      n_cmp++; if (rdata_le !== exp) begin n_err++; $display("FAIL load%0d_rdata: got %h exp %h", i, rdata_le, exp); end
      n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL load%0d_stall: got %b exp 0", i, stall_le); end
      next_cycle;
    end
    drive(0, 0, 2'd2, 0, 32'h10, 32'h0);
    @(negedge clk);
    n_cmp++; if (rdata_le !== 32'd0) begin n_err++; $display("FAIL novalid_rdata: got %h exp 0", rdata_le); end
    n_cmp++; if (a_le !== 32'h10) begin n_err++; $display("FAIL novalid_addr: got %h exp 10", a_le); end
    next_cycle;
  endtask

  task automatic test_word_store;
    drive(1, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++; if (we_le !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b exp 1", we_le); end
    n_cmp++; if (a_le !== 32'h20) begin n_err++; $display("FAIL sw_addr: got %h exp 20", a_le); end
    n_cmp++; if (wd_le !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wd: got %h exp deadbeef", wd_le); end
    n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL sw_stall: got %b exp 0", stall_le); end
    next_cycle;
    ref_le[8] = 32'hDEADBEEF;
    drive(1, 0, 2'd2, 0, 32'h20, 32'h0);
    @(negedge clk);
    n_cmp++; if (rdata_le !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_after_sw: got %h exp deadbeef", rdata_le); end
    next_cycle;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_wd;
    mem_le[8] = 32'hDEADBEEF; ref_le[8] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin drive(1, 1, 2'd0, 0, 32'h22, 32'h0000005A); exp_wd = 32'hDE5ABEEF; end
      else        begin drive(1, 1, 2'd1, 0, 32'h20, 32'h00001234); exp_wd = 32'hDE5A1234; end
      @(negedge clk);
      n_cmp++; if (stall_le !== 1'b1) begin n_err++; $display("FAIL b2b%0d_c1_stall: got %b exp 1", i, stall_le); end
      n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL b2b%0d_c1_we: got %b exp 0", i, we_le); end
      next_cycle;
      @(negedge clk);
      n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL b2b%0d_c2_stall: got %b exp 0", i, stall_le); end
      n_cmp++; if (we_le !== 1'b1) begin n_err++; $display("FAIL b2b%0d_c2_we: got %b exp 1", i, we_le); end
      n_cmp++; if (a_le !== 32'h20) begin n_err++; $display("FAIL b2b%0d_c2_addr: got %h exp 20", i, a_le); end
      n_cmp++; if (wd_le !== exp_wd) begin n_err++; $display("FAIL b2b%0d_c2_wd: got %h exp %h", i, wd_le, exp_wd); end
      n_cmp++; if (rdata_le !== 32'd0) begin n_err++; $display("FAIL b2b%0d_c2_rdata: got %h exp 0", i, rdata_le); end
      next_cycle;
    end
    ref_le[8] = 32'hDE5A1234;
    n_cmp++; if (mem_le[8] !== 32'hDE5A1234) begin n_err++; $display("FAIL b2b_final: got %h exp de5a1234", mem_le[8]); end
  endtask

  task automatic test_misalign;
    int idx;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 0, 2'd1, 0, 32'h13, 32'h0); idx = 4; end
        1: begin drive(1, 0, 2'd2, 0, 32'h22, 32'h0); idx = 8; end
        2: begin drive(1, 1, 2'd2, 0, 32'h21, 32'h01020304); idx = 8; end
        default: begin drive(1, 1, 2'd3, 0, 32'h00, 32'h05060708); idx = 0; end
      endcase
      @(negedge clk);
      n_cmp++; if (mis_le !== 1'b1) begin n_err++; $display("FAIL mis%0d_flag: got %b exp 1", i, mis_le); end
      n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL mis%0d_we: got %b exp 0", i, we_le); end
      n_cmp++; if (rdata_le !== 32'd0) begin n_err++; $display("FAIL mis%0d_rdata: got %h exp 0", i, rdata_le); end
      n_cmp++; if (stall_le !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall: got %b exp 0", i, stall_le); end
      next_cycle;
      n_cmp++; if (mem_le[idx] !== ref_le[idx]) begin n_err++; $display("FAIL mis%0d_mem: got %h exp %h", i, mem_le[idx], ref_le[idx]); end
    end
  endtask

  task automatic test_reset_rmw;
    mem_le[12] = 32'h11223344; ref_le[12] = 32'h11223344;
    drive(1, 1, 2'd0, 0, 32'h30, 32'h000000FF);
    @(negedge clk);
    n_cmp++; if (stall_le !== 1'b1) begin n_err++; $display("FAIL rstrmw_c1_stall: got %b exp 1", stall_le); end
    next_cycle;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL rstrmw_c2_we: got %b exp 0", we_le); end
    next_cycle;
    reset = 1'b0;
    drive(0, 0, 2'd0, 0, 32'h30, 32'h0);
    @(negedge clk);
    n_cmp++; if (we_le !== 1'b0) begin n_err++; $display("FAIL rstrmw_after_we: got %b exp 0", we_le); end
    next_cycle;
    n_cmp++; if (mem_le[12] !== 32'h11223344) begin n_err++; $display("FAIL rstrmw_mem: got %h exp 11223344", mem_le[12]); end
    drive(1, 0, 2'd2, 0, 32'h30, 32'h0);
    @(negedge clk);
    n_cmp++; if (rdata_le !== 32'h11223344) begin n_err++; $display("FAIL rstrmw_idle_lw: got %h exp 11223344", rdata_le); end
    next_cycle;
  endtask

  task automatic test_big_endian;
    mem_be[0] = 32'h8899AABB; ref_be[0] = 32'h8899AABB;
    drive(1, 0, 2'd0, 1, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (rdata_be !== 32'h00000088) begin n_err++; $display("FAIL be_lbu: got %h exp 88", rdata_be); end
    next_cycle;
    drive(1, 1, 2'd0, 0, 32'h3, 32'h00000000);
    @(negedge clk);
    n_cmp++; if (stall_be !== 1'b1) begin n_err++; $display("FAIL be_sb_stall: got %b exp 1", stall_be); end
    next_cycle;
    @(negedge clk);
    n_cmp++; if (wd_be !== 32'h8899AA00) begin n_err++; $display("FAIL be_sb_wd: got %h exp 8899aa00", wd_be); end
    next_cycle;
    n_cmp++; if (mem_be[0] !== 32'h8899AA00) begin n_err++; $display("FAIL be_sb_mem: got %h exp 8899aa00", mem_be[0]); end
  endtask

  task automatic test_random;
    bit v, we, un, mis;
    int sz, a, off, idx;
    logic [31:0] wd, exp_le, exp_be;
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
    next_cycle;
    for (int i = 0; i < 64; i++) begin
      mem_le[i] = $urandom; mem_be[i] = $urandom;
      ref_le[i] = mem_le[i]; ref_be[i] = mem_be[i];
    end
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 7) != 0); we = $urandom_range(0, 1); un = $urandom_range(0, 1);
      sz = $urandom_range(0, 3); a = $urandom_range(0, 255); wd = $urandom;
      off = a % 4; idx = a / 4;
      mis = v && ref_mis(a, sz);
      drive(v, we, 2'(sz), un, 32'(a), wd);
      @(negedge clk);
      n_cmp++; if (mis_le !== mis) begin n_err++; $display("FAIL rnd%0d_mis: got %b exp %b", n, mis_le, mis); end
      if (!v || mis) begin
        n_cmp++; if ({we_le, stall_le, rdata_le} !== 34'd0) begin n_err++; $display("FAIL rnd%0d_idle: we %b stall %b rdata %h exp 0", n, we_le, stall_le, rdata_le); end
      end else if (!we) begin
        exp_le = ref_load(ref_le[idx], off, sz, un, 0);
        exp_be = ref_load(ref_be[idx], off, sz, un, 1);
        n_cmp++; if (rdata_le !== exp_le) begin n_err++; $display("FAIL rnd%0d_ld_le: got %h exp %h", n, rdata_le, exp_le); end
        n_cmp++; if (rdata_be !== exp_be) begin n_err++; $display("FAIL rnd%0d_ld_be: got %h exp %h", n, rdata_be, exp_be); end
      end else if (sz == 2) begin
        n_cmp++; if ({we_le, stall_le} !== 2'b10) begin n_err++; $display("FAIL rnd%0d_sw: we %b stall %b exp 1/0", n, we_le, stall_le); end
      end else begin
        n_cmp++; if ({we_le, stall_le, stall_be} !== 3'b011) begin n_err++; $display("FAIL rnd%0d_rmw_c1: we %b stall %b/%b exp 0/1/1", n, we_le, stall_le, stall_be); end
        next_cycle;
        @(negedge clk);
        n_cmp++; if ({we_le, we_be, stall_le} !== 3'b110) begin n_err++; $display("FAIL rnd%0d_rmw_c2: we %b/%b stall %b exp 1/1/0", n, we_le, we_be, stall_le); end
      end
      if (v && !mis && we) begin
        ref_le[idx] = ref_store(ref_le[idx], off, sz, wd, 0);
        ref_be[idx] = ref_store(ref_be[idx], off, sz, wd, 1);
      end
      next_cycle;
      n_cmp++; if (mem_le[idx] !== ref_le[idx]) begin n_err++; $display("FAIL rnd%0d_mem_le: got %h exp %h", n, mem_le[idx], ref_le[idx]); end
      n_cmp++; if (mem_be[idx] !== ref_be[idx]) begin n_err++; $display("FAIL rnd%0d_mem_be: got %h exp %h", n, mem_be[idx], ref_be[idx]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      mem_le[i] = $urandom; mem_be[i] = $urandom;
      ref_le[i] = mem_le[i]; ref_be[i] = mem_be[i];
    end
    next_cycle;
    test_reset;
    test_loads;
    test_word_store;
    test_back_to_back;
    test_misalign;
    test_reset_rmw;
    test_big_endian;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator that sits in the M stage between the pipeline and the word-addressed data memory.
- The memory exposes only an asynchronous word read and a synchronous, whole-word write (we_M, a, wd, rd).
- This block adds byte and halfword loads, with sign or zero extension.
- It adds byte and halfword stores using a 2-cycle read-modify-write (RMW) with a pipeline stall.
- It detects misaligned accesses.

Parameters:
BIG_ENDIAN, 0, byte-lane order. 0: byte offset 0 = bits 7:0. 1: byte offset 0 = bits 31:24.
CHECK_ALIGN, 1, 1: misaligned accesses flag misalign and are suppressed. 0: low address bits are ignored (forced aligned).

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  M-stage memory op present this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as misaligned).
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
rdata  out  32  load result, combinational.
stall  out  1  holds the pipeline; high during cycle 1 of a sub-word store.
misalign  out  1  combinational flag; high when the current request is misaligned.
mem_we  out  1  memory write enable.
mem_a  out  32  memory byte address; bits 1:0 always 0.
mem_wd  out  32  memory write word.
mem_rd  in  32  memory asynchronous read word.

Behaviour:
- Reset: state = IDLE, latched address and data registers = 0.
  - While reset is high: mem_we = 0, stall = 0, misalign = 0, rdata = 0.
  - mem_we is gated by ~reset, so no memory write can occur in any cycle with reset high.
- FSM states: IDLE, RMW_WR.
- Alignment rules:
  - Byte: always aligned.
  - Halfword: addr[0] = 0.
  - Word: addr[1:0] = 0.
  - size = 3: always misaligned.
- Misaligned request (CHECK_ALIGN = 1):
  - misalign = 1, mem_we = 0, rdata = 0, stall = 0, state stays IDLE.
- IDLE, no request: mem_a = {req_addr[31:2], 2'b00} regardless of req_valid; mem_we = 0.
- IDLE, load:
  - Lane selected by addr[1:0] and BIG_ENDIAN.
  - Extended per req_unsigned; word loads pass mem_rd unchanged.
  - Zero-cycle latency (combinational from mem_rd); no stall.
- IDLE, word store: mem_we = 1, mem_wd = req_wdata in the same cycle; no stall; state stays IDLE.
- IDLE, byte or halfword store (cycle 1):
  - stall = 1, mem_we = 0.
  - Merge req_wdata[7:0] or [15:0] into mem_rd at the selected lane.
  - Latch the merged word and the aligned address.
  - Next state RMW_WR.
- RMW_WR (cycle 2):
  - mem_we = 1, mem_a = latched address, mem_wd = latched merged word.
  - stall = 0; req_* inputs are ignored; rdata = 0.
  - Next state IDLE.
  - The pipeline advances at the end of this cycle, so the next request is seen in the following IDLE cycle.
- Reset asserted in RMW_WR: the write is suppressed, state returns to IDLE, and the latched data is discarded.
- Reset asserted on cycle 1: the latch is not taken and state stays IDLE.
- Back-to-back sub-word stores: each takes 2 cycles, giving a throughput of one per 2 cycles.
- A load after a store to the same word in the next cycle sees the written data, because the memory write lands on the RMW_WR posedge.
- req_valid = 0: no memory write and no stall; rdata = 0.

Decomposition:
- Shared package:
  - size encodings (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2);
  - state encodings (ST_IDLE, ST_RMW_WR);
  - a lane-index function for (addr[1:0], size, BIG_ENDIAN).
- One combinational sub-module, lsu_lane_mux, provides both:
  - load extract and extend;
  - store merge.
  This keeps the FSM file small and lets the lane logic be unit-tested in isolation.

Test Plan:
1. mem word at 0x10 = 0x8899AABB, little-endian. Expected results:
   - lb  @0x11 -> rdata = 0xFFFFFFAA
   - lbu @0x11 -> 0x000000AA
   - lh  @0x12 -> 0xFFFF8899
   - lhu @0x12 -> 0x00008899
   - stall = 0 throughout.
2. sw 0xDEADBEEF @0x20 -> mem_we = 1 same cycle, mem_a = 0x20, no stall; a following lw @0x20 returns 0xDEADBEEF.
3. mem[0x20] = 0xDEADBEEF; sb 0x5A @0x22 and sh 0x1234 @0x20 back-to-back:
   - each gives stall = 1 for one cycle, then mem_we = 1;
   - final word = 0xDE5A1234;
   - the second request is taken only after the first completes.
4. lh @0x13, lw @0x22, sw @0x21, size = 3 @0x0 -> each: misalign = 1, mem_we = 0, rdata = 0, no stall, no memory change.
5. sb 0xFF @0x30 (word 0x11223344), with reset high in RMW_WR -> no write, mem[0x30] still 0x11223344, state IDLE next cycle.
6. BIG_ENDIAN = 1, word 0x8899AABB: lbu @0x0 -> 0x88; sb 0x00 @0x3 -> word 0x8899AA00.
